// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider.
//   div_state_e : FSM state encoding (IDLE=0, RUN=1, DONE=2; 3 is unused and recovers to IDLE)
//   cnt_width() : width of the iteration counter for a given operand width
package div_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } div_state_e;

  // Counter must hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/ripple_sub.sv
// N-bit ripple-borrow subtractor built from full-subtractor cells.
//   a_i    : minuend
//   b_i    : subtrahend
//   bin_i  : borrow in to bit 0
//   diff_o : a_i - b_i - bin_i (mod 2^N)
//   bout_o : borrow out of the MSB (1 when a_i < b_i + bin_i)
module ripple_sub #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         bin_i,
  output logic [N-1:0] diff_o,
  output logic         bout_o
);

  logic [N:0] borrow;

  assign borrow[0] = bin_i;

  for (genvar i = 0; i < int'(N); i++) begin : g_cell
    assign diff_o[i]     = a_i[i] ^ b_i[i] ^ borrow[i];
    assign borrow[i + 1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & borrow[i]);
  end

  assign bout_o = borrow[N];

endmodule

// File: rtl/restoring_div4.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk_94       : clock, rising edge
//   rst_n_94     : asynchronous active-low reset
//   start_94     : request, accepted only while ready_94=1
//   dividend_94  : dividend, captured on accepted start
//   divisor_94   : divisor, captured on accepted start
//   ready_94     : 1 in IDLE and DONE
//   done_94      : one-cycle pulse, results valid from this cycle
//   quotient_94  : quotient (all ones on divide by zero)
//   remainder_94 : remainder (dividend on divide by zero)
//   div_zero_94  : captured divisor was zero
module restoring_div4
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_94,
  input  logic             rst_n_94,
  input  logic             start_94,
  input  logic [WIDTH-1:0] dividend_94,
  input  logic [WIDTH-1:0] divisor_94,
  output logic             ready_94,
  output logic             done_94,
  output logic [WIDTH-1:0] quotient_94,
  output logic [WIDTH-1:0] remainder_94,
  output logic             div_zero_94
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] qsh_q, qsh_d;   // dividend shifting out, quotient shifting in
  logic [WIDTH:0]   rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             start_ok;

  // After a restore step the MSB of the partial remainder is always zero, so it
  // never feeds the next trial value.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[WIDTH];

  assign trial    = {rem_q[WIDTH-1:0], qsh_q[WIDTH-1]};
  assign start_ok = start_94 & ready_q;

  ripple_sub #(
    .N(WIDTH + 1)
  ) u_sub (
    .a_i   (trial),
    .b_i   ({1'b0, dvs_q}),
    .bin_i (1'b0),
    .diff_o(diff),
    .bout_o(borrow)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qsh_d   = qsh_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    ready_d = ready_q;

    case (state_q)
      StRun: begin
        // Borrow out is the only compare: no borrow means the divisor fits.
        if (borrow) begin
          rem_d = trial;
          qsh_d = {qsh_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d = diff;
          qsh_d = {qsh_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
          done_d  = 1'b1;
          ready_d = 1'b1;
          quot_d  = qsh_d;
          remo_d  = rem_d[WIDTH-1:0];
        end
      end
      StIdle, StDone: begin
        state_d = StIdle;
        ready_d = 1'b1;
        if (start_ok) begin
          qsh_d  = dividend_94;
          dvs_d  = divisor_94;
          rem_d  = '0;
          quot_d = '0;
          remo_d = '0;
          dz_d   = 1'b0;
          if (divisor_94 == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
            quot_d  = '1;
            remo_d  = dividend_94;
            dz_d    = 1'b1;
          end else begin
            state_d = StRun;
            cnt_d   = CntW'(WIDTH);
            ready_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_94 or negedge rst_n_94) begin
    if (!rst_n_94) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      qsh_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qsh_q   <= qsh_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign ready_94     = ready_q;
  assign done_94      = done_q;
  assign quotient_94  = quot_q;
  assign remainder_94 = remo_q;
  assign div_zero_94  = dz_q;

endmodule
